pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
Holds the architectural program counter and fetches 16-bit instruction words from instruction memory through a req/ack handshake. It presents each fetched instruction to decode with a valid/ready handshake. It sits directly upstream of the PC-select mux: it drives curr_pc and the fetched opcode to the mux, and it loads the mux's next_pc when decode consumes the instruction. Multi-cycle design with one instruction in flight at a time.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
TIMEOUT, 16, cycles of unanswered request before fetch_err pulses. Legal range 2..255.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
halt  input  1  when high, no new fetch is started; an outstanding fetch still completes.
next_pc  input  16  next PC from the PC-select mux, valid while instr_valid=1.
imem_req  output  1  instruction memory request.
imem_addr  output  16  word address of the request; always equals curr_pc.
imem_ack  input  1  memory response strobe; imem_rdata is valid in the same cycle.
imem_rdata  input  16  instruction word.
curr_pc  output  16  PC of the held or in-flight instruction.
instr  output  16  fetched instruction; opcode = instr[15:12].
instr_valid  output  1  instr is valid for decode.
instr_ready  input  1  decode accepts instr this cycle.
fetch_err  output  1  one-cycle pulse on request timeout.
fetch_count  output  16  retired-fetch counter (see Optional Feature).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=S_IDLE, curr_pc=RESET_PC, instr=16'h0000.
  - instr_valid=0, imem_req=0, fetch_err=0, timeout counter=0, fetch_count=0.
  - Reset mid-transaction abandons the fetch; any later ack is ignored.
- All outputs are registered. imem_addr is driven directly from the curr_pc register.
- S_IDLE:
  - imem_req=0, instr_valid=0.
  - If halt=0, go to S_FETCH; imem_req rises on the next edge.
  - If halt=1, remain in S_IDLE.
- S_FETCH:
  - imem_req=1; imem_addr=curr_pc, held stable until ack.
  - On imem_ack=1: instr<=imem_rdata, instr_valid<=1, imem_req<=0, counter<=0, go to S_HOLD.
  - An ack in the first cycle of req is legal.
  - Without ack, the counter increments. When counter==TIMEOUT-1 and there is no ack: fetch_err<=1 for one cycle, counter<=0, stay in S_FETCH with req held (automatic retry).
  - An ack in the same cycle the counter would expire wins: no fetch_err.
- S_HOLD:
  - instr_valid=1; instr and curr_pc are held stable.
  - On instr_ready=1: curr_pc<=next_pc, instr_valid<=0. Go to S_FETCH if halt=0, or S_IDLE if halt=1. This is the only cycle curr_pc changes.
  - No ready: stay in S_HOLD indefinitely; halt is ignored.
- imem_ack outside S_FETCH is ignored.
- Latency:
  - Ack at cycle t gives instr_valid=1 at t+1.
  - Ready at cycle t gives the new curr_pc and imem_req=1 at t+1 (halt=0).
  - Minimum 2 cycles per instruction.
- Arithmetic: curr_pc is loaded from next_pc verbatim; wrap-around (16'hFFFF to 16'h0000) is the mux's responsibility and is accepted unchanged.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: fetch_count increments by 1 on every instr_valid&&instr_ready handshake. It wraps at 16'hFFFF to 0 and resets to 0.
- Undefined: fetch_count is tied to 16'h0000 and no counter register is synthesised. Port list is unchanged.

Test Plan:
- Release reset, halt=0, memory acks 1 cycle after req with 16'hB005, ready=1, next_pc=16'h0005 -> imem_addr=16'h0000 first; instr=16'hB005 and instr_valid=1 one cycle after ack; curr_pc=16'h0005 and imem_req=1 one cycle after the handshake.
- Instruction held with instr_ready=0 for 10 cycles while next_pc toggles -> instr, curr_pc and instr_valid remain stable; no new imem_req.
- TIMEOUT=16, ack withheld 40 cycles -> fetch_err pulses at 16th and 32nd request cycles; imem_req stays high with imem_addr unchanged; ack at cycle 41 completes normally.
- halt=1 asserted while in S_HOLD, then ready=1 -> curr_pc updates, state S_IDLE, imem_req stays 0; deassert halt -> req asserted on next edge.
- rst_n pulled low while in S_FETCH at curr_pc=16'h0123 -> imem_req=0 immediately; curr_pc=RESET_PC; a stray ack after reset release is ignored.
- FETCH_PERF_CNT_EN defined, 5 completed handshakes -> fetch_count=5. Undefined -> fetch_count=0 throughout.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit: holds the architectural PC, fetches 16-bit instruction words over a req/ack memory port and hands them to decode.
// Latency: ack at cycle t gives instr_valid at t+1; ready at cycle t gives the new curr_pc and imem_req at t+1 (minimum 2 cycles/instruction).
// Backpressure: an accepted instruction is held, with imem_req low, until instr_ready; halt stops new fetches but never cancels an outstanding one.
//
// Ports:
//   clk, rst_n            - rising-edge clock, asynchronous active-low reset
//   halt                  - suppresses the start of a new fetch
//   next_pc               - PC loaded on the decode handshake (from the PC-select mux)
//   imem_req/addr/ack/rdata - instruction memory handshake; imem_addr mirrors curr_pc
//   curr_pc, instr, instr_valid, instr_ready - decode-side hold/handshake
//   fetch_err             - one-cycle pulse when a request goes TIMEOUT cycles unanswered
//   fetch_count           - retired-fetch counter, live only when FETCH_PERF_CNT_EN is defined
//
// Parameters: RESET_PC (PC after reset), TIMEOUT (2..255, request cycles before fetch_err).
// Optional macro: FETCH_PERF_CNT_EN enables the fetch_count register; otherwise fetch_count is 0.
module pc_fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        halt,
   input  logic [15:0] next_pc,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_rdata,
   output logic [15:0] curr_pc,
   output logic [15:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic        fetch_err,
   output logic [15:0] fetch_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   // Last count value before the timeout fires; counter starts at 0 on the first request cycle.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic [15:0] pc_q, pc_nxt;
   logic [15:0] instr_q, instr_nxt;
   logic [7:0]  cnt_q, cnt_nxt;
   logic        req_q, req_nxt;
   logic        vld_q, vld_nxt;
   logic        err_q, err_nxt;
   logic        handshake;

   assign handshake = vld_q & instr_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= 16'h0000;
         cnt_q   <= 8'd0;
         req_q   <= 1'b0;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         pc_q    <= pc_nxt;
         instr_q <= instr_nxt;
         cnt_q   <= cnt_nxt;
         req_q   <= req_nxt;
         vld_q   <= vld_nxt;
         err_q   <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc_q;
      instr_nxt = instr_q;
      cnt_nxt   = cnt_q;
      err_nxt   = 1'b0;

      case (state)
         S_IDLE: begin
            if (!halt) state_nxt = S_FETCH;
         end
         S_FETCH: begin
            // An ack always wins over a timeout expiring in the same cycle.
            if (imem_ack) begin
               instr_nxt = imem_rdata;
               cnt_nxt   = 8'd0;
               state_nxt = S_HOLD;
            end else if (cnt_q == TO_LAST) begin
               // Flag the timeout and keep requesting the same address.
               err_nxt = 1'b1;
               cnt_nxt = 8'd0;
            end else begin
               cnt_nxt = cnt_q + 8'd1;
            end
         end
         S_HOLD: begin
            // Halt only matters at the handshake; without ready we hold forever.
            if (handshake) begin
               pc_nxt    = next_pc;
               state_nxt = halt ? S_IDLE : S_FETCH;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      // Request/valid are registered copies of the next state so they change with it.
      req_nxt = (state_nxt == S_FETCH);
      vld_nxt = (state_nxt == S_HOLD);
   end

   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign curr_pc     = pc_q;
   assign instr       = instr_q;
   assign instr_valid = vld_q;
   assign fetch_err   = err_q;

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] perf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_q <= 16'h0000;
      end else if (handshake) begin
         perf_q <= perf_q + 16'd1;
      end
   end

   assign fetch_count = perf_q;
`else
   assign fetch_count = 16'h0000;
`endif

endmodule
